// File: rtl/mem_responder_if.sv
// Request/response bundle between the pipeline memory stage (master) and the
// data-memory responder (slave).
interface mem_responder_if;
    logic [2:0]  mem_cmd;
    logic        mem_cmd_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    modport master (
        output mem_cmd,
        output mem_addr,
        output mem_wdata,
        output mem_wmask,
        input  mem_cmd_ready,
        input  mem_rdata,
        input  mem_rdata_valid
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wmask,
        output mem_cmd_ready,
        output mem_rdata,
        output mem_rdata_valid
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word-addressed data memory with per-bit write masks.
// Optional MEM_RESPONDER_RANGE_CHECK_EN: drop/zero accesses beyond the array instead of wrapping.
module mem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2     // legal range 1..15
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_responder_if.slave bus
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    write_q;
    logic                    oor_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [31:0]             wmask_q;
    logic                    valid_q;

    logic                    accept_d;
    logic                    addr_oor_d;
    logic [DEPTH_LOG2-1:0]   addr_idx_d;
    logic                    enter_done_d;
    logic [DEPTH_LOG2-1:0]   rd_idx_d;
    logic                    rd_is_read_d;
    logic                    rd_oor_d;
    logic                    rd_en_d;
    logic                    wr_en_d;
    logic [31:0]             rdata_w;
    logic                    unused_addr;

    assign unused_addr = ^bus.mem_addr;

    assign accept_d   = (state_q == ST_IDLE) &&
                        ((bus.mem_cmd == CMD_READ) || (bus.mem_cmd == CMD_WRITE));
    assign addr_idx_d = bus.mem_addr[DEPTH_LOG2+1:2];

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    assign addr_oor_d = ({1'b0, bus.mem_addr} >= (33'd4 << DEPTH_LOG2));
`else
    assign addr_oor_d = 1'b0;
`endif

    // The array is read on the edge that enters DONE so the registered read
    // lands exactly in the response cycle; with LATENCY==1 that edge is the
    // acceptance edge itself, so the address comes straight from the bus.
    assign enter_done_d = (accept_d && (LATENCY == 1)) ||
                          ((state_q == ST_WAIT) && (cnt_q == 4'd1));
    assign rd_idx_d     = (state_q == ST_IDLE) ? addr_idx_d : idx_q;
    assign rd_is_read_d = (state_q == ST_IDLE) ? (bus.mem_cmd == CMD_READ) : !write_q;
    assign rd_oor_d     = (state_q == ST_IDLE) ? addr_oor_d : oor_q;
    assign rd_en_d      = rst_n && enter_done_d && rd_is_read_d;
    assign wr_en_d      = rst_n && (state_q == ST_DONE) && write_q && !oor_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wmask_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        write_q <= (bus.mem_cmd == CMD_WRITE);
                        oor_q   <= addr_oor_d;
                        idx_q   <= addr_idx_d;
                        wdata_q <= bus.mem_wdata;
                        wmask_q <= bus.mem_wmask;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                        if ((bus.mem_cmd == CMD_READ) && addr_oor_d) begin
                            $display("MEM.OOR addr=%h", bus.mem_addr);
                        end
`endif
                        if (LATENCY == 1) begin
                            state_q <= ST_DONE;
                            cnt_q   <= 4'd0;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // One 1-bit-wide column per data bit: the per-bit mask becomes a plain
    // column write enable, so a masked write needs no read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_col
            logic col_mem [DEPTH];
            logic rbit_q;

            always_ff @(posedge clk) begin
                if (wr_en_d && wmask_q[gi]) begin
                    col_mem[idx_q] <= wdata_q[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rbit_q <= 1'b0;
                end else if (rd_en_d) begin
                    rbit_q <= rd_oor_d ? 1'b0 : col_mem[rd_idx_d];
                end
            end

            assign rdata_w[gi] = rbit_q;
        end
    endgenerate

    assign bus.mem_cmd_ready   = (state_q == ST_IDLE);
    assign bus.mem_rdata       = rdata_w;
    assign bus.mem_rdata_valid = valid_q;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: cycle-level timeline model compared every
// cycle, plus literal expectations for each directed read-back.
module tb_mem_responder;
    localparam int DL    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_responder_if bus_if();

    mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted command owns the memory until its due cycle
    // (acceptance cycle + LAT); reads answer in the due cycle, writes land at its end.
    logic [31:0] mmem [DEPTH];
    int          cyc = 0;
    bit          pend = 0, p_write = 0, p_oor = 0, m_valid = 0, m_known = 0;
    int          due = 0, p_idx = 0;
    logic [31:0] p_wdata = 0, p_wmask = 0, m_rdata = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pend    = 0;
            m_valid = 0;
            m_rdata = 32'd0;
            m_known = 1;
        end else begin
            if (pend) begin
                if (due == cyc) begin
                    if (p_write && !p_oor)
                        mmem[p_idx] = (mmem[p_idx] & ~p_wmask) | (p_wdata & p_wmask);
                    pend = 0;
                end
            end else if (bus_if.mem_cmd == 3'd1 || bus_if.mem_cmd == 3'd2) begin
                pend    = 1;
                due     = cyc + LAT;
                p_write = (bus_if.mem_cmd == 3'd2);
                p_idx   = int'((bus_if.mem_addr >> 2) % 32'(DEPTH));
                p_wdata = bus_if.mem_wdata;
                p_wmask = bus_if.mem_wmask;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                p_oor   = (64'(bus_if.mem_addr) >= 64'(4 * DEPTH));
`else
                p_oor   = 0;
`endif
            end
            m_valid = pend && !p_write && (due == cyc + 1);
            if (m_valid) m_rdata = p_oor ? 32'd0 : mmem[p_idx];
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("cmd_ready", {31'd0, bus_if.mem_cmd_ready}, {31'd0, !pend});
            chk("rdata_valid", {31'd0, bus_if.mem_rdata_valid}, {31'd0, m_valid});
            chk("rdata", bus_if.mem_rdata, m_rdata);
        end
    end

    // Present a command for one cycle on the first ready cycle; returns at the
    // negedge of the cycle after acceptance.
    task automatic issue(input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] m);
        int t = 0;
        while (!bus_if.mem_cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: actual=0 expected=1 at %0t", $time);
        end
        $display("txn cmd=%0d addr=%h wdata=%h wmask=%h", c, a, w, m);
        bus_if.mem_cmd   = c;
        bus_if.mem_addr  = a;
        bus_if.mem_wdata = w;
        bus_if.mem_wmask = m;
        @(negedge clk);
        bus_if.mem_cmd   = 3'd0;
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        int lat = 1;
        issue(3'd1, a, 32'd0, 32'd0);
        while (!bus_if.mem_rdata_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_valid"}, {31'd0, bus_if.mem_rdata_valid}, 32'd1);
        chk({name, "_latency"}, 32'(lat), 32'(LAT));
        chk(name, bus_if.mem_rdata, exp);
        @(negedge clk);
        chk({name, "_pulse_end"}, {31'd0, bus_if.mem_rdata_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus_if.mem_cmd   = 3'd0;
        bus_if.mem_addr  = 32'd0;
        bus_if.mem_wdata = 32'd0;
        bus_if.mem_wmask = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_ready", {31'd0, bus_if.mem_cmd_ready}, 32'd1);
        chk("reset_valid", {31'd0, bus_if.mem_rdata_valid}, 32'd0);
        chk("reset_rdata", bus_if.mem_rdata, 32'd0);

        for (int i = 0; i < DEPTH; i++) issue(3'd2, 32'(i * 4), 32'd0, 32'hFFFF_FFFF);

        // Full write then read-back, with the busy window checked literally.
        issue(3'd2, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        chk("wr_busy_1", {31'd0, bus_if.mem_cmd_ready}, 32'd0);
        @(negedge clk);
        chk("wr_busy_2", {31'd0, bus_if.mem_cmd_ready}, 32'd0);
        @(negedge clk);
        chk("wr_ready_again", {31'd0, bus_if.mem_cmd_ready}, 32'd1);
        do_read("rd_deadbeef", 32'h10, 32'hDEAD_BEEF);

        issue(3'd2, 32'h20, 32'h1122_3344, 32'hFFFF_FFFF);
        issue(3'd2, 32'h20, 32'hAABB_CCDD, 32'h0000_FF00);
        do_read("rd_masked", 32'h20, 32'h1122_CC44);

        issue(3'd2, 32'h3C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'h3C, 32'h0000_0000, 32'hF0F0_F0F0);
        do_read("rd_mask_nibbles", 32'h3C, 32'h0F0F_0F0F);

        issue(3'd2, 32'h20, 32'h0000_0055, 32'hFFFF_FFFF);
        do_read("rd_low_bits_ignored", 32'h23, 32'h0000_0055);

        bus_if.mem_cmd = 3'd5;
        @(negedge clk);
        bus_if.mem_cmd = 3'd0;
        chk("illegal_cmd_ready", {31'd0, bus_if.mem_cmd_ready}, 32'd1);
        @(negedge clk);
        chk("illegal_cmd_ready_2", {31'd0, bus_if.mem_cmd_ready}, 32'd1);

        // Reset one cycle after a write is accepted: the write must vanish.
        issue(3'd2, 32'h30, 32'h0000_0000, 32'hFFFF_FFFF);
        issue(3'd2, 32'h30, 32'h1234_5678, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midwr_reset_ready", {31'd0, bus_if.mem_cmd_ready}, 32'd1);
        do_read("rd_after_midwr_reset", 32'h30, 32'h0000_0000);

        issue(3'd1, 32'h10, 32'd0, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("midrd_no_valid", {31'd0, bus_if.mem_rdata_valid}, 32'd0);
            @(negedge clk);
        end
        do_read("rd_after_midrd_reset", 32'h10, 32'hDEAD_BEEF);

        issue(3'd2, 32'h40, 32'h0000_0099, 32'hFFFF_FFFF);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        do_read("rd_word0_untouched", 32'h0, 32'h0000_0000);
        do_read("rd_oor_zero", 32'h40, 32'h0000_0000);
`else
        do_read("rd_word0_wrapped", 32'h0, 32'h0000_0099);
        do_read("rd_wrap_alias", 32'h40, 32'h0000_0099);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
